// File: rtl/rdma_pkg.sv
// Shared constants and types for the RDMA receive/transmit stream steering logic.
// Byte offsets index the first beat of an Ethernet/IPv4/UDP frame (byte n = tdata[8n+7:8n]).
package rdma_pkg;

    localparam logic [15:0] ROCE_UDP_PORT_DEFAULT = 16'd4791;

    localparam int ETHERTYPE_OFF = 12;
    localparam int IP_VHL_OFF    = 14;
    localparam int IP_PROTO_OFF  = 23;
    localparam int UDP_DPORT_OFF = 36;

    localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  IPV4_VHL_NO_OPT = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PASS_CU = 2'd1,
        ST_PASS_RE = 2'd2
    } demux_state_t;

endpackage

// File: rtl/rx_roce_classifier.sv
// Combinational first-beat match: flags IPv4 (no options) / UDP frames aimed at the RoCEv2 port.
// Fields arrive pre-extracted in network byte order so only the matched bytes enter this block.
module rx_roce_classifier
    import rdma_pkg::*;
#(
    parameter logic [15:0] ROCE_UDP_PORT = ROCE_UDP_PORT_DEFAULT
) (
    input  logic [15:0] ethertype,
    input  logic [7:0]  ip_vhl,
    input  logic [7:0]  ip_proto,
    input  logic [15:0] udp_dport,
    input  logic        dport_keep,
    input  logic        re_enable,
    output logic        is_roce
);

    // dport_keep guards against runts whose destination port bytes are not present.
    assign is_roce = re_enable
                   & dport_keep
                   & (ethertype == ETHERTYPE_IPV4)
                   & (ip_vhl    == IPV4_VHL_NO_OPT)
                   & (ip_proto  == IP_PROTO_UDP)
                   & (udp_dport == ROCE_UDP_PORT);

endmodule

// File: rtl/rx_axis_tdata_demux.sv
// Splits the MAC RX stream between the Corundum RX path (cu) and the RDMA engine (re), per frame.
// Optional frame counters are built when RX_DEMUX_STATS_EN is defined.
module rx_axis_tdata_demux
    import rdma_pkg::*;
#(
    parameter int          PORTS              = 1,
    parameter int          AXIS_DATA_WIDTH    = 512 * 2 ** $clog2(PORTS),
    parameter int          AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH / 8,
    parameter int          AXIS_RX_ID_WIDTH   = 10,
    parameter int          AXIS_RX_DEST_WIDTH = $clog2(PORTS) + 4,
    parameter int          AXIS_RX_USER_WIDTH = 128,
    parameter logic [15:0] ROCE_UDP_PORT      = ROCE_UDP_PORT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          re_enable,

    input  logic [AXIS_DATA_WIDTH-1:0]    s_rx_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]    s_rx_axis_tkeep,
    input  logic                          s_rx_axis_tvalid,
    output logic                          s_rx_axis_tready,
    input  logic                          s_rx_axis_tlast,
    input  logic [AXIS_RX_ID_WIDTH-1:0]   s_rx_axis_tid,
    input  logic [AXIS_RX_DEST_WIDTH-1:0] s_rx_axis_tdest,
    input  logic [AXIS_RX_USER_WIDTH-1:0] s_rx_axis_tuser,

    output logic [AXIS_DATA_WIDTH-1:0]    cu_rx_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]    cu_rx_axis_tkeep,
    output logic                          cu_rx_axis_tvalid,
    input  logic                          cu_rx_axis_tready,
    output logic                          cu_rx_axis_tlast,
    output logic [AXIS_RX_ID_WIDTH-1:0]   cu_rx_axis_tid,
    output logic [AXIS_RX_DEST_WIDTH-1:0] cu_rx_axis_tdest,
    output logic [AXIS_RX_USER_WIDTH-1:0] cu_rx_axis_tuser,

    output logic [AXIS_DATA_WIDTH-1:0]    re_rx_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]    re_rx_axis_tkeep,
    output logic                          re_rx_axis_tvalid,
    input  logic                          re_rx_axis_tready,
    output logic                          re_rx_axis_tlast,
    output logic [AXIS_RX_ID_WIDTH-1:0]   re_rx_axis_tid,
    output logic [AXIS_RX_DEST_WIDTH-1:0] re_rx_axis_tdest,
    output logic [AXIS_RX_USER_WIDTH-1:0] re_rx_axis_tuser
`ifdef RX_DEMUX_STATS_EN
    ,
    output logic [31:0]                   stat_cu_pkts,
    output logic [31:0]                   stat_re_pkts,
    output logic [31:0]                   stat_bad_pkts
`endif
);

    if (AXIS_DATA_WIDTH < 512) begin : g_width_check
        $error("rx_axis_tdata_demux: AXIS_DATA_WIDTH must be at least 512");
    end

    demux_state_t state, state_next;

    logic                          is_roce;
    logic                          route_re;
    logic                          in_hs;
    logic                          out_hs;
    logic                          tgt_ready;
    logic                          reg_valid;
    logic                          reg_tgt;
    logic [AXIS_DATA_WIDTH-1:0]    reg_tdata;
    logic [AXIS_KEEP_WIDTH-1:0]    reg_tkeep;
    logic                          reg_tlast;
    logic [AXIS_RX_ID_WIDTH-1:0]   reg_tid;
    logic [AXIS_RX_DEST_WIDTH-1:0] reg_tdest;
    logic [AXIS_RX_USER_WIDTH-1:0] reg_tuser;

    rx_roce_classifier #(
        .ROCE_UDP_PORT (ROCE_UDP_PORT)
    ) u_classifier (
        .ethertype  ({s_rx_axis_tdata[8*ETHERTYPE_OFF +: 8], s_rx_axis_tdata[8*(ETHERTYPE_OFF+1) +: 8]}),
        .ip_vhl     (s_rx_axis_tdata[8*IP_VHL_OFF +: 8]),
        .ip_proto   (s_rx_axis_tdata[8*IP_PROTO_OFF +: 8]),
        .udp_dport  ({s_rx_axis_tdata[8*UDP_DPORT_OFF +: 8], s_rx_axis_tdata[8*(UDP_DPORT_OFF+1) +: 8]}),
        .dport_keep (s_rx_axis_tkeep[UDP_DPORT_OFF+1]),
        .re_enable  (re_enable),
        .is_roce    (is_roce)
    );

    // Only the latched target's tready matters; the other sink is ignored.
    assign tgt_ready        = reg_tgt ? re_rx_axis_tready : cu_rx_axis_tready;
    assign out_hs           = reg_valid & tgt_ready;
    assign s_rx_axis_tready = ~reg_valid | tgt_ready;
    assign in_hs            = s_rx_axis_tvalid & s_rx_axis_tready;
    assign route_re         = (state == ST_IDLE) ? is_roce : (state == ST_PASS_RE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (in_hs) begin
            if (s_rx_axis_tlast) begin
                state_next = ST_IDLE;
            end else if (state == ST_IDLE) begin
                state_next = is_roce ? ST_PASS_RE : ST_PASS_CU;
            end
        end
    end

    // Single shared beat register; a new beat may replace the old one in the cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_valid <= 1'b0;
            reg_tgt   <= 1'b0;
            reg_tdata <= '0;
            reg_tkeep <= '0;
            reg_tlast <= 1'b0;
            reg_tid   <= '0;
            reg_tdest <= '0;
            reg_tuser <= '0;
        end else if (in_hs) begin
            reg_valid <= 1'b1;
            reg_tgt   <= route_re;
            reg_tdata <= s_rx_axis_tdata;
            reg_tkeep <= s_rx_axis_tkeep;
            reg_tlast <= s_rx_axis_tlast;
            reg_tid   <= s_rx_axis_tid;
            reg_tdest <= s_rx_axis_tdest;
            reg_tuser <= s_rx_axis_tuser;
        end else if (out_hs) begin
            reg_valid <= 1'b0;
        end
    end

    assign cu_rx_axis_tvalid = reg_valid & ~reg_tgt;
    assign re_rx_axis_tvalid = reg_valid & reg_tgt;

    assign cu_rx_axis_tdata  = reg_tdata;
    assign cu_rx_axis_tkeep  = reg_tkeep;
    assign cu_rx_axis_tlast  = reg_tlast;
    assign cu_rx_axis_tid    = reg_tid;
    assign cu_rx_axis_tdest  = reg_tdest;
    assign cu_rx_axis_tuser  = reg_tuser;

    assign re_rx_axis_tdata  = reg_tdata;
    assign re_rx_axis_tkeep  = reg_tkeep;
    assign re_rx_axis_tlast  = reg_tlast;
    assign re_rx_axis_tid    = reg_tid;
    assign re_rx_axis_tdest  = reg_tdest;
    assign re_rx_axis_tuser  = reg_tuser;

`ifdef RX_DEMUX_STATS_EN
    // Frames are counted when their last beat leaves; bad frames also count toward their sink.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cu_pkts  <= '0;
            stat_re_pkts  <= '0;
            stat_bad_pkts <= '0;
        end else if (out_hs && reg_tlast) begin
            if (reg_tgt) begin
                stat_re_pkts <= stat_re_pkts + 32'd1;
            end else begin
                stat_cu_pkts <= stat_cu_pkts + 32'd1;
            end
            if (reg_tuser[0]) begin
                stat_bad_pkts <= stat_bad_pkts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_axis_tdata_demux.sv
// Scoreboard bench for rx_axis_tdata_demux: randomized frames, reference classification from byte rules.
// Counter checks are active when RX_DEMUX_STATS_EN is defined.
`timescale 1ns/1ps
module tb_rx_axis_tdata_demux;

    localparam int DW  = 512;
    localparam int KW  = 64;
    localparam int IW  = 10;
    localparam int DSW = 4;
    localparam int UW  = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic re_enable;

    logic [DW-1:0]  s_tdata;
    logic [KW-1:0]  s_tkeep;
    logic           s_tvalid;
    logic           s_tready;
    logic           s_tlast;
    logic [IW-1:0]  s_tid;
    logic [DSW-1:0] s_tdest;
    logic [UW-1:0]  s_tuser;

    logic [DW-1:0]  cu_tdata,  re_tdata;
    logic [KW-1:0]  cu_tkeep,  re_tkeep;
    logic           cu_tvalid, re_tvalid;
    logic           cu_tready, re_tready;
    logic           cu_tlast,  re_tlast;
    logic [IW-1:0]  cu_tid,    re_tid;
    logic [DSW-1:0] cu_tdest,  re_tdest;
    logic [UW-1:0]  cu_tuser,  re_tuser;
`ifdef RX_DEMUX_STATS_EN
    logic [31:0] stat_cu_pkts, stat_re_pkts, stat_bad_pkts;
`endif

    rx_axis_tdata_demux #(.PORTS(1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .re_enable         (re_enable),
        .s_rx_axis_tdata   (s_tdata),
        .s_rx_axis_tkeep   (s_tkeep),
        .s_rx_axis_tvalid  (s_tvalid),
        .s_rx_axis_tready  (s_tready),
        .s_rx_axis_tlast   (s_tlast),
        .s_rx_axis_tid     (s_tid),
        .s_rx_axis_tdest   (s_tdest),
        .s_rx_axis_tuser   (s_tuser),
        .cu_rx_axis_tdata  (cu_tdata),
        .cu_rx_axis_tkeep  (cu_tkeep),
        .cu_rx_axis_tvalid (cu_tvalid),
        .cu_rx_axis_tready (cu_tready),
        .cu_rx_axis_tlast  (cu_tlast),
        .cu_rx_axis_tid    (cu_tid),
        .cu_rx_axis_tdest  (cu_tdest),
        .cu_rx_axis_tuser  (cu_tuser),
        .re_rx_axis_tdata  (re_tdata),
        .re_rx_axis_tkeep  (re_tkeep),
        .re_rx_axis_tvalid (re_tvalid),
        .re_rx_axis_tready (re_tready),
        .re_rx_axis_tlast  (re_tlast),
        .re_rx_axis_tid    (re_tid),
        .re_rx_axis_tdest  (re_tdest),
        .re_rx_axis_tuser  (re_tuser)
`ifdef RX_DEMUX_STATS_EN
        ,
        .stat_cu_pkts      (stat_cu_pkts),
        .stat_re_pkts      (stat_re_pkts),
        .stat_bad_pkts     (stat_bad_pkts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           sink;   // 1 = re, 0 = cu
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    beat_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int model_cu = 0, model_re = 0, model_bad = 0;
    int cyc = 0;
    bit cu_rand = 1'b0, re_rand = 1'b0;
    int re_stall = 0;
    bit track_gap = 1'b0, gap_seen = 1'b0;
    int last_pop = 0, gap_max = 0;
    bit count_stall = 1'b0;
    int stall_cycles = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sink readiness: changes shortly after each rising edge so it is stable when sampled.
    initial begin
        cu_tready = 1'b1;
        re_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            cu_tready = cu_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (re_stall > 0) begin
                re_tready = 1'b0;
                re_stall--;
            end else begin
                re_tready = re_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    initial begin : monitor
        logic          hold;
        logic          hold_re;
        logic [DW-1:0] hold_data;
        logic          sink_now;
        logic          exp_rdy;
        beat_t         e;
        hold = 1'b0;
        hold_re = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            check("valid_exclusive", DW'(cu_tvalid & re_tvalid), DW'(0));
            exp_rdy = !((cu_tvalid && !cu_tready) || (re_tvalid && !re_tready));
            check("s_tready", DW'(s_tready), DW'(exp_rdy));
            if (count_stall && !s_tready) stall_cycles++;
            if (hold) begin
                check("hold_valid", DW'(hold_re ? re_tvalid : cu_tvalid), DW'(1));
                check("hold_data", hold_re ? re_tdata : cu_tdata, hold_data);
            end
            if ((cu_tvalid && cu_tready) || (re_tvalid && re_tready)) begin
                sink_now = re_tvalid && re_tready;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: output beat on sink %0d with empty scoreboard, required none", sink_now);
                end else begin
                    e = exp_q.pop_front();
                    check("sink", DW'(sink_now), DW'(e.sink));
                    check("tdata", sink_now ? re_tdata : cu_tdata, e.data);
                    check("tkeep", DW'(sink_now ? re_tkeep : cu_tkeep), DW'(e.keep));
                    check("tlast", DW'(sink_now ? re_tlast : cu_tlast), DW'(e.last));
                    check("tid", DW'(sink_now ? re_tid : cu_tid), DW'(e.id));
                    check("tdest", DW'(sink_now ? re_tdest : cu_tdest), DW'(e.dest));
                    check("tuser", DW'(sink_now ? re_tuser : cu_tuser), DW'(e.user));
                    if (track_gap) begin
                        if (gap_seen && (cyc - last_pop) > gap_max) gap_max = cyc - last_pop;
                        last_pop = cyc;
                        gap_seen = 1'b1;
                    end
                end
            end
            hold = (cu_tvalid && !cu_tready) || (re_tvalid && !re_tready);
            hold_re = re_tvalid;
            hold_data = re_tvalid ? re_tdata : cu_tdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // kind: 0 RoCE, 1 TCP, 2 VLAN, 3 IPv4 options, 4 other UDP port, 5 random bytes
    function automatic logic [DW-1:0] header(input int kind);
        logic [DW-1:0] d;
        d = rand_data();
        d[8*12 +: 8] = 8'h08;
        d[8*13 +: 8] = 8'h00;
        d[8*14 +: 8] = 8'h45;
        d[8*23 +: 8] = 8'h11;
        d[8*36 +: 8] = 8'h12;
        d[8*37 +: 8] = 8'hB7;
        case (kind)
            1: d[8*23 +: 8] = 8'h06;
            2: d[8*12 +: 8] = 8'h81;
            3: d[8*14 +: 8] = 8'h46;
            4: d[8*37 +: 8] = 8'hB8;
            5: d = rand_data();
            default: ;
        endcase
        return d;
    endfunction

    function automatic bit model_is_roce(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic en);
        logic [7:0] b [64];
        for (int i = 0; i < 64; i++) b[i] = d[8*i +: 8];
        return en && k[37] && b[12] == 8'h08 && b[13] == 8'h00 && b[14] == 8'h45
            && b[23] == 8'h11 && {b[36], b[37]} == 16'd4791;
    endfunction

    task automatic send_beat(input beat_t b, output bit ok);
        int waited;
        waited = 0;
        ok = 1'b0;
        s_tdata = b.data;
        s_tkeep = b.keep;
        s_tlast = b.last;
        s_tid = b.id;
        s_tdest = b.dest;
        s_tuser = b.user;
        s_tvalid = 1'b1;
        while (waited < 500) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: s_tready stayed 0 for %0d cycles, required 1", waited);
            s_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(b);
        #1;
    endtask

    task automatic send_frame(input int kind, input int nbeats, input bit bad,
                              input int first_keep_bytes, input int toggle_en_at, input int stop_after);
        beat_t b;
        bit cls;
        bit ok;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [KW-1:0]  one;
        int nsend;
        cls = 1'b0;
        one = 1;
        id = IW'($urandom);
        dest = DSW'($urandom);
        nsend = (stop_after > 0) ? stop_after : nbeats;
        for (int i = 0; i < nsend; i++) begin
            if (i == toggle_en_at) re_enable = 1'b0;
            b.data = (i == 0) ? header(kind) : rand_data();
            b.keep = (i == 0 && first_keep_bytes < KW) ? ((one << first_keep_bytes) - one) : '1;
            b.last = (i == nbeats - 1);
            b.id = id;
            b.dest = dest;
            b.user = {$urandom, $urandom, $urandom, $urandom};
            b.user[0] = bad;
            if (i == 0) cls = model_is_roce(b.data, b.keep, re_enable);
            b.sink = cls;
            send_beat(b, ok);
            if (!ok) return;
            if (b.last) begin
                if (cls) model_re++;
                else model_cu++;
                if (bad) model_bad++;
            end
        end
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
`ifdef RX_DEMUX_STATS_EN
        check({tag, "_stat_cu"},  DW'(stat_cu_pkts),  DW'(32'(model_cu)));
        check({tag, "_stat_re"},  DW'(stat_re_pkts),  DW'(32'(model_re)));
        check({tag, "_stat_bad"}, DW'(stat_bad_pkts), DW'(32'(model_bad)));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tlast = 1'b0;
        s_tid = '0;
        s_tdest = '0;
        s_tuser = '0;
        re_enable = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cu_tvalid", DW'(cu_tvalid), DW'(0));
        check("rst_re_tvalid", DW'(re_tvalid), DW'(0));
        check("rst_s_tready", DW'(s_tready), DW'(1));
        check("rst_cu_tdata", cu_tdata, '0);
        check("rst_re_tdata", re_tdata, '0);
        check_stats("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Long RoCE frame, both sinks ready
        send_frame(0, 64, 1'b0, KW, -1, 0);
        idle();
        drain();
        check_stats("roce64");

        // TCP frame immediately followed by RoCE frame
        track_gap = 1'b1;
        gap_seen = 1'b0;
        gap_max = 0;
        send_frame(1, 4, 1'b0, KW, -1, 0);
        send_frame(0, 4, 1'b0, KW, -1, 0);
        idle();
        drain();
        track_gap = 1'b0;
        check("no_bubble_gap", DW'(gap_max), DW'(1));
        check_stats("b2b");

        // RoCE frame with a 5-cycle re stall, cu_tready toggling
        cu_rand = 1'b1;
        stall_cycles = 0;
        count_stall = 1'b1;
        fork
            send_frame(0, 12, 1'b0, KW, -1, 0);
            begin
                repeat (5) @(posedge clk);
                #1 re_stall = 5;
            end
        join
        idle();
        drain();
        count_stall = 1'b0;
        cu_rand = 1'b0;
        check("stall_cycles", DW'(stall_cycles), DW'(5));

        // re_enable drops on third beat: frame stays on re, next RoCE frame goes to cu
        send_frame(0, 6, 1'b0, KW, 2, 0);
        send_frame(0, 3, 1'b0, KW, -1, 0);
        idle();
        drain();
        re_enable = 1'b1;
        check_stats("re_en");

        // Reset in the middle of a stalled RoCE frame
        send_frame(0, 8, 1'b0, KW, -1, 2);
        re_stall = 50;
        idle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cu_tvalid", DW'(cu_tvalid), DW'(0));
        check("arst_re_tvalid", DW'(re_tvalid), DW'(0));
        check("arst_s_tready", DW'(s_tready), DW'(1));
        exp_q.delete();
        model_cu = 0;
        model_re = 0;
        model_bad = 0;
        re_stall = 0;
        check_stats("arst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(0, 4, 1'b0, KW, -1, 0);
        idle();
        drain();
        check_stats("post_rst");

        // Single-beat runt (20 bytes) flagged bad
        send_frame(0, 1, 1'b1, 20, -1, 0);
        idle();
        drain();
        check_stats("runt");

        // Randomized mix with random backpressure on both sinks
        cu_rand = 1'b1;
        re_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            re_enable = ($urandom_range(0, 3) != 0);
            send_frame($urandom_range(0, 5), $urandom_range(1, 6), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 4) == 0) ? $urandom_range(1, 63) : KW, -1, 0);
            if ($urandom_range(0, 1) == 1) begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        idle();
        drain();
        cu_rand = 1'b0;
        re_rand = 1'b0;
        re_enable = 1'b1;
        check_stats("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
